// File: rtl/ddc_core_mc.sv
// ddc_core_mc: time-multiplexed multi-channel digital down-converter core.
// Each sample is mixed with its DDS cos/sin pair in a 3-stage pipeline.
// The mixed sample is then accumulated per channel over dec_len samples.
// Each dump is scaled, saturated and placed in a one-entry output register.
// Build option: define DDC_MC_ROUND_EN to round half up at the dump.
// Without it, the dump truncates.
module ddc_core_mc #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 14,
    parameter int DDS_W  = 14,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 8,
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*DATA_W-1:0]   data_in,
    input  logic [2*DDS_W-1:0]    dds_in,
    input  logic [CW-1:0]         ch_in,
    input  logic                  valid_in,
    input  logic [15:0]           dec_len,
    input  logic                  resync,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [2*OUT_W-1:0]    ddc_out,
    output logic [CW-1:0]         ch_out,
    output logic                  overrun
);

    localparam int PW    = DATA_W + DDS_W;
    localparam int P     = PW + 1;
    localparam int ACC_W = P + 16;
    // Working width for scaling: wide enough for the rounding bias and saturation compare.
    localparam int WW    = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;
    localparam logic signed [WW-1:0] OUT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] OUT_MIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef DDC_MC_ROUND_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WW-1:0] RND_BIAS =
        (SHIFT > 0) ? ({{(WW-1){1'b0}}, 1'b1} << RND_SH) : {WW{1'b0}};
`endif

    // Scale an accumulator to the output width: optional bias, arithmetic shift, saturate.
    function automatic logic [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [WW-1:0] wide;
        logic [OUT_W-1:0]     res;
        wide = WW'(acc);
`ifdef DDC_MC_ROUND_EN
        wide = wide + RND_BIAS;
`endif
        wide = wide >>> SHIFT;
        if (wide > OUT_MAX) begin
            res = OUT_MAX[OUT_W-1:0];
        end else if (wide < OUT_MIN) begin
            res = OUT_MIN[OUT_W-1:0];
        end else begin
            res = wide[OUT_W-1:0];
        end
        return res;
    endfunction

    logic signed [DATA_W-1:0] di_s1_r, dq_s1_r;
    logic signed [DDS_W-1:0]  cos_s1_r, sin_s1_r;
    logic [CW-1:0]            ch_s1_r, ch_s2_r, ch_s3_r;
    logic                     vld_s1_r, vld_s2_r, vld_s3_r;
    logic signed [PW-1:0]     p_ic_r, p_qs_r, p_qc_r, p_is_r;
    logic signed [P-1:0]      mix_i_r, mix_q_r;

    logic signed [ACC_W-1:0]  acc_i_r [N_CH];
    logic signed [ACC_W-1:0]  acc_q_r [N_CH];
    logic [15:0]              cnt_r   [N_CH];
    logic [15:0]              len_r   [N_CH];

    logic [CW-1:0]            ch_sel_s;
    logic [15:0]              len_eff_s, len_use_s, cnt_nxt_s;
    logic                     first_s, dump_s;
    logic signed [ACC_W-1:0]  acc_i_nxt_s, acc_q_nxt_s;
    logic [OUT_W-1:0]         out_i_s, out_q_s;

    // Mixer stage 1: register the qualified input sample; resync kills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_s1_r <= 1'b0;
            di_s1_r  <= {DATA_W{1'b0}};
            dq_s1_r  <= {DATA_W{1'b0}};
            cos_s1_r <= {DDS_W{1'b0}};
            sin_s1_r <= {DDS_W{1'b0}};
            ch_s1_r  <= {CW{1'b0}};
        end else begin
            vld_s1_r <= valid_in && !resync;
            if (valid_in) begin
                di_s1_r  <= data_in[DATA_W-1:0];
                dq_s1_r  <= data_in[2*DATA_W-1:DATA_W];
                cos_s1_r <= dds_in[DDS_W-1:0];
                sin_s1_r <= dds_in[2*DDS_W-1:DDS_W];
                ch_s1_r  <= ch_in;
            end
        end
    end

    // Mixer stage 2: the four full-precision cross products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_s2_r <= 1'b0;
            ch_s2_r  <= {CW{1'b0}};
            p_ic_r   <= {PW{1'b0}};
            p_qs_r   <= {PW{1'b0}};
            p_qc_r   <= {PW{1'b0}};
            p_is_r   <= {PW{1'b0}};
        end else begin
            vld_s2_r <= vld_s1_r && !resync;
            if (vld_s1_r) begin
                ch_s2_r <= ch_s1_r;
                p_ic_r  <= PW'(di_s1_r) * PW'(cos_s1_r);
                p_qs_r  <= PW'(dq_s1_r) * PW'(sin_s1_r);
                p_qc_r  <= PW'(dq_s1_r) * PW'(cos_s1_r);
                p_is_r  <= PW'(di_s1_r) * PW'(sin_s1_r);
            end
        end
    end

    // Mixer stage 3: I = Di*cos + Dq*sin, Q = Dq*cos - Di*sin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_s3_r <= 1'b0;
            ch_s3_r  <= {CW{1'b0}};
            mix_i_r  <= {P{1'b0}};
            mix_q_r  <= {P{1'b0}};
        end else begin
            vld_s3_r <= vld_s2_r && !resync;
            if (vld_s2_r) begin
                ch_s3_r <= ch_s2_r;
                mix_i_r <= P'(p_ic_r) + P'(p_qs_r);
                mix_q_r <= P'(p_qc_r) - P'(p_is_r);
            end
        end
    end

    // Frame bookkeeping for the channel of the mixed sample, plus dump detection and scaling.
    always_comb begin
        ch_sel_s  = (N_CH == 1) ? {CW{1'b0}} : ch_s3_r;
        len_eff_s = (dec_len == 16'd0) ? 16'd1 : dec_len;
        first_s   = (cnt_r[ch_sel_s] == 16'd0);
        cnt_nxt_s = cnt_r[ch_sel_s] + 16'd1;
        if (first_s) begin
            len_use_s   = len_eff_s;
            acc_i_nxt_s = ACC_W'(mix_i_r);
            acc_q_nxt_s = ACC_W'(mix_q_r);
        end else begin
            len_use_s   = len_r[ch_sel_s];
            acc_i_nxt_s = acc_i_r[ch_sel_s] + ACC_W'(mix_i_r);
            acc_q_nxt_s = acc_q_r[ch_sel_s] + ACC_W'(mix_q_r);
        end
        dump_s  = vld_s3_r && !resync && (cnt_nxt_s == len_use_s);
        out_i_s = scale_sat(acc_i_nxt_s);
        out_q_s = scale_sat(acc_q_nxt_s);
    end

    // Per-channel accumulators, sample counters and latched frame length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_i_r[k] <= {ACC_W{1'b0}};
                acc_q_r[k] <= {ACC_W{1'b0}};
                cnt_r[k]   <= 16'd0;
                len_r[k]   <= 16'd0;
            end
        end else if (resync) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_i_r[k] <= {ACC_W{1'b0}};
                acc_q_r[k] <= {ACC_W{1'b0}};
                cnt_r[k]   <= 16'd0;
            end
        end else if (vld_s3_r) begin
            acc_i_r[ch_sel_s] <= acc_i_nxt_s;
            acc_q_r[ch_sel_s] <= acc_q_nxt_s;
            len_r[ch_sel_s]   <= len_use_s;
            cnt_r[ch_sel_s]   <= dump_s ? 16'd0 : cnt_nxt_s;
        end
    end

    // One-entry output holding register with a sticky overrun flag for dropped dumps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            ddc_out   <= {(2*OUT_W){1'b0}};
            ch_out    <= {CW{1'b0}};
            overrun   <= 1'b0;
        end else if (dump_s) begin
            if (!valid_out || ready_in) begin
                valid_out <= 1'b1;
                ddc_out   <= {out_q_s, out_i_s};
                ch_out    <= ch_sel_s;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddc_core_mc.sv
// tb_ddc_core_mc: directed and randomized bench for ddc_core_mc.
// The reference model keeps per-channel running sums of the mixed products.
// Expected outputs are queued in order.
module tb_ddc_core_mc;

    localparam int N_CH   = 4;
    localparam int DATA_W = 14;
    localparam int DDS_W  = 14;
    localparam int OUT_W  = 32;
    localparam int SHIFT  = 2;
    localparam int CW     = 2;
    localparam int DW2    = 2 * DATA_W;
    localparam int SW2    = 2 * DDS_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [DW2-1:0]     data_in;
    logic [SW2-1:0]     dds_in;
    logic [CW-1:0]      ch_in;
    logic               valid_in;
    logic [15:0]        dec_len;
    logic               resync;
    logic               ready_in;
    logic               valid_out;
    logic [2*OUT_W-1:0] ddc_out;
    logic [CW-1:0]      ch_out;
    logic               overrun;

    ddc_core_mc #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DDS_W(DDS_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dds_in(dds_in), .ch_in(ch_in),
        .valid_in(valid_in), .dec_len(dec_len), .resync(resync), .ready_in(ready_in),
        .valid_out(valid_out), .ddc_out(ddc_out), .ch_out(ch_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { longint i; longint q; int ch; } exp_t;
    exp_t   exp_q[$];
    longint m_sum_i [N_CH];
    longint m_sum_q [N_CH];
    int     m_cnt   [N_CH];
    int     m_len   [N_CH];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] obs_i();
        logic signed [OUT_W-1:0] v;
        v = ddc_out[OUT_W-1:0];
        return v;
    endfunction

    function automatic logic signed [63:0] obs_q();
        logic signed [OUT_W-1:0] v;
        v = ddc_out[2*OUT_W-1:OUT_W];
        return v;
    endfunction

    // floor(sum / 2^SHIFT) (with optional half-up bias), clamped to the signed output range
    function automatic longint m_scale(input longint a);
        longint d, q, mx, mn;
        d  = 64'sd1 <<< SHIFT;
        mx = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (OUT_W - 1));
`ifdef DDC_MC_ROUND_EN
        if (SHIFT > 0) a = a + d / 64'sd2;
`endif
        q = a / d;
        if ((a % d) != 64'sd0 && a < 64'sd0) q = q - 64'sd1;
        if (q > mx) q = mx;
        if (q < mn) q = mn;
        return q;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < N_CH; k++) begin
            m_cnt[k] = 0; m_sum_i[k] = 0; m_sum_q[k] = 0; m_len[k] = 1;
        end
    endfunction

    // advance one clock; an output being accepted this cycle is checked against the queue
    task automatic tick();
        exp_t e;
        if (valid_out === 1'b1 && ready_in === 1'b1) begin
            chk("out_expected", 64'(exp_q.size() > 0), 64'sd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_i", obs_i(), e.i);
                chk("out_q", obs_q(), e.q);
                chk("out_ch", ch_out, e.ch);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int di, input int dq, input int c, input int s, input int ch);
        longint mi, mq;
        exp_t   e;
        data_in  = {DATA_W'(dq), DATA_W'(di)};
        dds_in   = {DDS_W'(s), DDS_W'(c)};
        ch_in    = CW'(ch);
        valid_in = 1'b1;
        mi = longint'(di) * c + longint'(dq) * s;
        mq = longint'(dq) * c - longint'(di) * s;
        if (m_cnt[ch] == 0) begin
            m_len[ch]   = (dec_len == 16'd0) ? 1 : int'(dec_len);
            m_sum_i[ch] = 0;
            m_sum_q[ch] = 0;
        end
        m_sum_i[ch] += mi;
        m_sum_q[ch] += mq;
        m_cnt[ch]++;
        if (m_cnt[ch] == m_len[ch]) begin
            e.i = m_scale(m_sum_i[ch]); e.q = m_scale(m_sum_q[ch]); e.ch = ch;
            exp_q.push_back(e);
            m_cnt[ch] = 0;
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int k = 0; k < n; k++) begin
            data_in = DW2'($urandom);
            dds_in  = SW2'($urandom);
            ch_in   = CW'($urandom);
            tick();
        end
    endtask

    task automatic do_resync();
        valid_in = 1'b0;
        resync   = 1'b1;
        tick();
        resync   = 1'b0;
        for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
    endtask

    task automatic wait_out(input string tag, input int bound);
        int n;
        n = 0;
        while (valid_out !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, valid_out, 64'sd1);
    endtask

    function automatic int rnd_s(input int lim);
        return int'($urandom_range(0, 2 * lim + 1)) - lim - 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; data_in = '0; dds_in = '0; ch_in = '0; valid_in = 1'b0;
        dec_len = 16'd1; resync = 1'b0; ready_in = 1'b1;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_out, 64'sd0);
        chk("rst_data", ddc_out, 64'sd0);
        chk("rst_ch", ch_out, 64'sd0);
        chk("rst_overrun", overrun, 64'sd0);
        rst = 1'b0;
        tick();

        // single-sample frame: value and 4-cycle latency
        dec_len = 16'd1;
        send(100, 0, 8191, 0, 0);
        lat = 1;
        while (valid_out !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        chk("latency", lat, 64'sd4);
        chk("dl1_i", obs_i(), 64'sd204775);
        chk("dl1_q", obs_q(), 64'sd0);
        idle(2);

        // round-robin, 4 samples per channel
        dec_len = 16'd4;
        do_resync();
        for (int n = 0; n < 16; n++) send(1, 0, 1, 0, n % 4);
        idle(8);
        chk("rr_drained", exp_q.size(), 64'sd0);

        // rounding vs truncation of an accumulated 6
        dec_len = 16'd2;
        do_resync();
        send(3, 0, 1, 0, 0);
        send(3, 0, 1, 0, 0);
        wait_out("rnd_seen", 10);
`ifdef DDC_MC_ROUND_EN
        chk("rnd_i", obs_i(), 64'sd2);
`else
        chk("rnd_i", obs_i(), 64'sd1);
`endif
        idle(2);

        // randomized phases, dec_len 0..7, random channels and gaps
        for (int ph = 0; ph < 4; ph++) begin
            dec_len = (ph == 0) ? 16'd0 : 16'($urandom_range(1, 7));
            do_resync();
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(rnd_s(8191), rnd_s(8191), rnd_s(8191), rnd_s(8191), int'($urandom_range(0, N_CH - 1)));
            end
            idle(8);
            chk("rand_drained", exp_q.size(), 64'sd0);
        end

        // positive and negative saturation
        dec_len = 16'd64;
        do_resync();
        for (int n = 0; n < 64; n++) send(-8192, -8192, -8192, -8192, 0);
        wait_out("satp_seen", 10);
        chk("satp_i", obs_i(), 64'sd2147483647);
        chk("satp_q", obs_q(), 64'sd0);
        idle(2);
        dec_len = 16'd128;
        do_resync();
        for (int n = 0; n < 128; n++) send(-8192, 8191, 8191, -8192, 0);
        wait_out("satn_seen", 10);
        chk("satn_i", obs_i(), -64'sd2147483648);
        idle(2);
        chk("ovr_clean", overrun, 64'sd0);

        // backpressure: first dump held, second dropped, overrun sticky
        dec_len = 16'd1;
        do_resync();
        ready_in = 1'b0;
        send(50, 0, 100, 0, 0);
        wait_out("bp_seen", 10);
        send(7, 0, 100, 0, 1);
        idle(6);
        chk("bp_valid", valid_out, 64'sd1);
        chk("bp_hold_i", obs_i(), 64'sd1250);
        chk("bp_hold_ch", ch_out, 64'sd0);
        chk("bp_overrun", overrun, 64'sd1);
        ready_in = 1'b1;
        tick();
        chk("bp_dropped_pending", exp_q.size(), 64'sd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("bp_valid_after", valid_out, 64'sd0);
        chk("bp_overrun_sticky", overrun, 64'sd1);

        // resync after 2 of 4 samples: next output covers only the 4 later samples
        dec_len = 16'd4;
        do_resync();
        send(5, 0, 1, 0, 0);
        send(5, 0, 1, 0, 0);
        do_resync();
        for (int n = 1; n <= 4; n++) send(n, 0, 1, 0, 0);
        wait_out("rs_seen", 10);
`ifdef DDC_MC_ROUND_EN
        chk("rs_i", obs_i(), 64'sd3);
`else
        chk("rs_i", obs_i(), 64'sd2);
`endif
        idle(3);

        // reset mid-cycle with a held output and overrun set
        dec_len = 16'd1;
        ready_in = 1'b0;
        send(9, 0, 100, 0, 2);
        wait_out("pre_rst_seen", 10);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", valid_out, 64'sd0);
        chk("mrst_data", ddc_out, 64'sd0);
        chk("mrst_ch", ch_out, 64'sd0);
        chk("mrst_overrun", overrun, 64'sd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        exp_q.delete();
        ready_in = 1'b1;
        dec_len = 16'd4;

        // no output before a full frame after reset
        for (int n = 0; n < 3; n++) send(2, 1, 3, 1, 1);
        idle(6);
        chk("post_rst_quiet", valid_out, 64'sd0);
        send(2, 1, 3, 1, 1);
        wait_out("post_rst_seen", 10);
        idle(4);
        chk("final_drained", exp_q.size(), 64'sd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddc_core_mc.md
DDC_CORE_MC -- requirements
Module: ddc_core_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of time-multiplexed channels (power of two, 1..64).
REQ-002 SHALL have parameter DATA_W, default 14: signed width of each ADC I/Q component.
REQ-003 SHALL have parameter DDS_W, default 14: signed width of each DDS cos/sin component.
REQ-004 SHALL have parameter OUT_W, default 32: signed width of each output I/Q component.
REQ-005 SHALL have parameter SHIFT, default 8: arithmetic right shift applied to accumulators at dump.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port data_in  input  2*DATA_W  [2*DATA_W-1:DATA_W] Q, [DATA_W-1:0] I.
REQ-009 SHALL have port dds_in  input  2*DDS_W  [2*DDS_W-1:DDS_W] sin, [DDS_W-1:0] cos, aligned with data_in.
REQ-010 SHALL have port ch_in  input  CW=max(1,log2 N_CH)  channel tag of the current sample.
REQ-011 SHALL have port valid_in  input  1  data_in/dds_in/ch_in qualifier.
REQ-012 SHALL have port dec_len  input  16  samples per channel per output; 0 treated as 1.
REQ-013 SHALL have port resync  input  1  single-cycle pulse: restart all decimation frames.
REQ-014 SHALL have port ready_in  input  1  downstream accepts ddc_out.
REQ-015 SHALL have port valid_out  output  1  ddc_out/ch_out valid.
REQ-016 SHALL have port ddc_out  output  2*OUT_W  [2*OUT_W-1:OUT_W] Q, [OUT_W-1:0] I.
REQ-017 SHALL have port ch_out  output  CW  channel of ddc_out.
REQ-018 SHALL have port overrun  output  1  sticky: a dump was dropped.

Function
REQ-019 Mixer SHALL compute, full precision (P = DATA_W+DDS_W+1 bits), I = Di*cos + Dq*sin and Q = Dq*cos - Di*sin.
REQ-020 Mixer pipeline SHALL be 3 registered stages (input, product, sum); valid/ch travel alongside.
REQ-021 Each channel SHALL own an ACC_W = P+16 bit I and Q accumulator plus a 16-bit sample counter.
REQ-022 The first mixed sample of a channel frame SHALL load the accumulator, later ones add to it; dec_len SHALL be latched per channel at that first sample.
REQ-023 When the channel's counter reaches its latched dec_len, the block SHALL dump: result = acc >>> SHIFT, saturated to OUT_W, counter and accumulator restarting at the next sample.
REQ-024 Latency SHALL be 4 cycles from the valid_in of a frame's last sample to valid_out, absent backpressure.
REQ-025 Output SHALL be a one-entry holding register; valid_out stays high and ddc_out/ch_out stable until valid_out && ready_in.
REQ-026 A dump arriving while the register is full and ready_in low SHALL be dropped, the register kept, overrun set.
REQ-027 A dump arriving in the same cycle as an accepting handshake SHALL load the register with no drop.
REQ-028 resync SHALL zero all counters and accumulators and discard in-flight mixer samples; the holding register and overrun SHALL be unaffected.
REQ-029 Samples with valid_in low SHALL not affect any state other than pipeline valid bits.
REQ-030 overrun SHALL clear only on rst.

Reset
REQ-031 rst SHALL asynchronously clear valid_out, ddc_out, ch_out, overrun, all accumulators, counters, latched dec_len and pipeline valids.
REQ-032 Outputs SHALL read 0 while rst is high; first valid_out SHALL occur no earlier than one full frame after rst deasserts.

Configuration
REQ-033 With macro DDC_MC_ROUND_EN defined, the dump SHALL add 2^(SHIFT-1) before shifting (round half up); when SHIFT=0 no bias SHALL be added.
REQ-034 Without DDC_MC_ROUND_EN, the dump SHALL truncate (pure arithmetic shift), and the rounding adder SHALL not be instantiated.

Verification
REQ-035 N_CH=1, SHIFT=0, dec_len=1, I=100,Q=0, cos=8191,sin=0, ready=1 -> ddc_out I=819100, Q=0, valid_out 4 cycles after valid_in.
REQ-036 N_CH=4 round-robin, dec_len=4, constant I=1,Q=0,cos=1,sin=0 -> one output per channel every 16 valid cycles, I=4, ch_out 0,1,2,3 in order.
REQ-037 ready_in held low across two dumps -> first result held stable, second dropped, overrun=1; ready high -> first accepted, overrun stays 1.
REQ-038 resync mid-frame after 2 of 4 samples -> next output covers exactly the 4 post-resync samples.
REQ-039 Full-scale I=Q=-8192, cos=sin=-8192, dec_len=65535, OUT_W=32, SHIFT=0 -> I saturates to 0x7FFFFFFF, Q=0.
REQ-040 SHIFT=2, accumulated I=6: with DDC_MC_ROUND_EN -> 2; without -> 1; rst asserted mid-frame -> all outputs 0 immediately.
